and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter CNT_W, default 8, width of the high-cycle counter (legal range 2..32).
REQ-002 Port declaration order SHALL be x, y, w, z, clk, rst, then the remaining outputs, so the first four ports bind positionally as (x, y, w, z).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 x  input  1  AND operand A.
REQ-006 y  input  1  AND operand B.
REQ-007 w  input  1  AND operand C.
REQ-008 z  output  1  combinational x AND y AND w.
REQ-009 z_q  output  1  z registered on clk.
REQ-010 z_rise  output  1  one-cycle pulse on a registered 0->1 transition of z.
REQ-011 z_fall  output  1  one-cycle pulse on a registered 1->0 transition of z.
REQ-012 hi_cnt  output  CNT_W  saturating count of clock edges sampling z=1; present only with AND_GATE_STATS_EN.
REQ-013 hi_sat  output  1  hi_cnt has reached all-ones; present only with AND_GATE_STATS_EN.

Function
REQ-014 z SHALL equal x & y & w with zero clock latency, independent of clk and rst.
REQ-015 z SHALL be 1 only when all three inputs are 1; any input at 0 forces z=0.
REQ-016 z_q SHALL take the value of z sampled at each rising clk edge (latency 1 cycle).
REQ-017 z_rise SHALL be 1 for exactly one cycle when sampled z=1 and the previous z_q=0.
REQ-018 z_fall SHALL be 1 for exactly one cycle when sampled z=0 and the previous z_q=1.
REQ-019 z_rise and z_fall SHALL never both be 1.
REQ-020 Input changes between clock edges SHALL affect z immediately but only the sampled value affects z_q, z_rise, z_fall, hi_cnt.
REQ-021 hi_cnt SHALL increment by 1 on each edge sampling z=1 and hold when z=0.
REQ-022 hi_cnt SHALL saturate at 2^CNT_W-1 with no wrap-around; hi_sat=1 while saturated.

Reset
REQ-023 With rst=1 at a rising edge: z_q=0, z_rise=0, z_fall=0, hi_cnt=0, hi_sat=0 on the following cycle.
REQ-024 rst SHALL have priority over all other updates, including a simultaneous z 0->1 transition.
REQ-025 z SHALL remain combinational and valid during reset.
REQ-026 The first edge after reset release sampling z=1 SHALL assert z_rise (reset state of z_q is 0).

Configuration
REQ-027 Macro AND_GATE_STATS_EN defined: hi_cnt and hi_sat ports and counter logic SHALL exist per REQ-021/022.
REQ-028 AND_GATE_STATS_EN undefined: hi_cnt and hi_sat ports SHALL be absent; all other behaviour unchanged.

Verification
REQ-029 Walk x,y,w from 000 through 100, 110, 111, 101, 100, 000, 010, 011 in 10 ns steps -> z=1 only in 111 interval, z=0 elsewhere, with no clock required.
REQ-030 All 8 input combinations applied statically -> z=1 only for x=y=w=1.
REQ-031 rst=1 for 2 cycles, then x=y=w=1 held 3 cycles -> z_q rises one cycle after first sampling edge, z_rise high exactly one cycle, hi_cnt=3.
REQ-032 z high for one cycle then w=0 -> z_rise one cycle, then z_fall one cycle, z_q returns 0.
REQ-033 CNT_W=2, z held high 6 cycles -> hi_cnt 1,2,3,3,3,3; hi_sat=1 from third count; no wrap.
REQ-034 rst asserted mid-run with z=1 and hi_cnt=5 -> next cycle z_q=0, hi_cnt=0, z still 1; first edge after release gives z_rise=1.

Source files
------------

// File: rtl/and_gate.sv
// Three-input AND with registered copy, edge pulses and an optional saturating high-time counter.
// Define AND_GATE_STATS_EN to add the hi_cnt/hi_sat ports and the counter behind them.
module and_gate #(
    parameter int CNT_W = 8
) (
    input  logic             x,
    input  logic             y,
    input  logic             w,
    output logic             z,
    input  logic             clk,
    input  logic             rst,
    output logic             z_q,
    output logic             z_rise,
    output logic             z_fall
`ifdef AND_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] hi_cnt,
    output logic             hi_sat
`endif
);

    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
        $error("and_gate: CNT_W must be within 2..32");
    end

    // z is purely combinational, so it stays valid while rst is held.
    assign z = x & y & w;

    // Edge pulses compare the newly sampled z against the previous z_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q    <= 1'b0;
            z_rise <= 1'b0;
            z_fall <= 1'b0;
        end else begin
            z_q    <= z;
            z_rise <= z & ~z_q;
            z_fall <= ~z & z_q;
        end
    end

`ifdef AND_GATE_STATS_EN
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_full;

    assign cnt_full = &cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (z && !cnt_full) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign hi_cnt = cnt_r;
    assign hi_sat = cnt_full;
`else
    // Counter stripped: only the AND path and the edge detector remain.
`endif

endmodule

// File: tb/tb_and_gate.sv
// Randomised and directed stimulus for and_gate, checked through a scoreboard queue
// filled by the driver and drained by an independent monitor.
module tb_and_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b0;
    logic y = 1'b0;
    logic w = 1'b0;
    logic z, z_q, z_rise, z_fall;
`ifdef AND_GATE_STATS_EN
    logic [7:0] hi_cnt;
    logic       hi_sat;
    logic       z2, z_q2, z_rise2, z_fall2;
    logic [1:0] hi_cnt2;
    logic       hi_sat2;
`endif

    always #5 clk = ~clk;

    and_gate #(.CNT_W(8)) dut (
        .x(x), .y(y), .w(w), .z(z), .clk(clk), .rst(rst),
        .z_q(z_q), .z_rise(z_rise), .z_fall(z_fall)
`ifdef AND_GATE_STATS_EN
        , .hi_cnt(hi_cnt), .hi_sat(hi_sat)
`endif
    );

`ifdef AND_GATE_STATS_EN
    and_gate #(.CNT_W(2)) dut2 (
        .x(x), .y(y), .w(w), .z(z2), .clk(clk), .rst(rst),
        .z_q(z_q2), .z_rise(z_rise2), .z_fall(z_fall2),
        .hi_cnt(hi_cnt2), .hi_sat(hi_sat2)
    );
`endif

    typedef struct {
        logic ez;
        logic ezq;
        logic erise;
        logic efall;
        int   ecnt8;
        int   ecnt2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: number of z=1 samples since the last reset and the last sampled z.
    int   ones = 0;
    logic last_zq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic b, input logic c);
        exp_t e;
        logic zs;
        @(negedge clk);
        rst = r;
        x = a;
        y = b;
        w = c;
        zs = a & b & c;
        if (r) begin
            ones    = 0;
            e.ezq   = 1'b0;
            e.erise = 1'b0;
            e.efall = 1'b0;
        end else begin
            e.ezq   = zs;
            e.erise = zs && !last_zq;
            e.efall = !zs && last_zq;
            if (zs) ones++;
        end
        last_zq = e.ezq;
        e.ez    = zs;
        e.ecnt8 = (ones > 255) ? 255 : ones;
        e.ecnt2 = (ones > 3) ? 3 : ones;
        sb.push_back(e);
    endtask

    // Monitor: every edge with a pending expectation is checked just after the edge.
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                m = sb.pop_front();
                chk("z", {31'b0, z}, {31'b0, m.ez});
                chk("z_q", {31'b0, z_q}, {31'b0, m.ezq});
                chk("z_rise", {31'b0, z_rise}, {31'b0, m.erise});
                chk("z_fall", {31'b0, z_fall}, {31'b0, m.efall});
`ifdef AND_GATE_STATS_EN
                chk("hi_cnt", {24'b0, hi_cnt}, m.ecnt8);
                chk("hi_sat", {31'b0, hi_sat}, {31'b0, m.ecnt8 == 255});
                chk("hi_cnt_w2", {30'b0, hi_cnt2}, m.ecnt2);
                chk("hi_sat_w2", {31'b0, hi_sat2}, {31'b0, m.ecnt2 == 3});
                chk("z_q_w2", {31'b0, z_q2}, {31'b0, m.ezq});
`endif
            end
        end
    end

    initial begin
        logic [2:0] walk [9];
        logic [2:0] v;
        logic       rr, ra, rb, rc;
        int         n;

        walk = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b010, 3'b011};

        // Combinational walk in 10 ns steps, independent of the clock phase.
        for (int i = 0; i < 9; i++) begin
            v = walk[i];
            {x, y, w} = v;
            #1;
            chk("walk_z", {31'b0, z}, {31'b0, (v == 3'b111)});
            #9;
        end

        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {x, y, w} = v;
            #1;
            chk("static_z", {31'b0, z}, {31'b0, (v[0] & v[1] & v[2])});
            #4;
        end

        // Reset for two cycles, then all-ones held for three.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1);

        // Single-cycle high then w drops.
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0);

        // Long high run to push the narrow counter into saturation.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 1'b1, 1'b1, 1'b1);

        // Mid-run reset while z=1 with count 5, then release with z still high.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);

        // Reset coinciding with a 0->1 transition of z.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(24) == 0);
            ra = ($urandom_range(3) != 0);
            rb = ($urandom_range(3) != 0);
            rc = ($urandom_range(3) != 0);
            drive(rr, ra, rb, rc);
        end

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
